hazard_ctrl: RTL



---
 rtl/hazard_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall, redirect flush and EX-operand forwarding control
// for a 5-stage pipeline, with a saturating stall-cycle counter.
`default_nettype none

module hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic [4:0]       id_rd_addr,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             id_writeback_en,
  input  logic             id_is_load,
  input  logic             ex_redirect,
  input  logic             mem_stall,
  output logic             stall_if,
  output logic             stall_id,
  output logic             bubble_ex,
  output logic             flush_id,
  output logic [1:0]       fwd_rs1_sel,
  output logic [1:0]       fwd_rs2_sel,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       wb_en;
    logic       is_load;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use_rs1;
    logic       use_rs2;
  } entry_t;

  localparam logic [1:0] SEL_RF  = 2'd0;
  localparam logic [1:0] SEL_MEM = 2'd1;
  localparam logic [1:0] SEL_WB  = 2'd2;

  entry_t ex_q;
  entry_t mem_q;
  entry_t wb_q;
  entry_t id_entry;
  logic   load_use;

  // x0 is hardwired, so an entry targeting it never produces a value to wait for.
  function automatic logic writer(input entry_t e, input logic [4:0] r);
    return e.valid && e.wb_en && (e.rd != 5'd0) && (e.rd == r);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic use_r, input logic [4:0] r,
                                         input entry_t m, input entry_t w);
    if (use_r && writer(m, r))      return SEL_MEM;
    else if (use_r && writer(w, r)) return SEL_WB;
    else                            return SEL_RF;
  endfunction

  always_comb begin
    load_use = id_valid && ex_q.valid && ex_q.is_load &&
               ((writer(ex_q, id_rs1_addr) && id_use_rs1) ||
                (writer(ex_q, id_rs2_addr) && id_use_rs2));
  end

  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    bubble_ex = 1'b0;
    flush_id  = 1'b0;
    if (rst) begin
      stall_if  = 1'b0;
    end else if (mem_stall) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
    end else if (ex_redirect) begin
      flush_id  = 1'b1;
      bubble_ex = 1'b1;
    end else if (load_use) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      bubble_ex = 1'b1;
    end
  end

  always_comb begin
    fwd_rs1_sel = SEL_RF;
    fwd_rs2_sel = SEL_RF;
    if (!rst && ex_q.valid) begin
      fwd_rs1_sel = fwd_sel(ex_q.use_rs1, ex_q.rs1, mem_q, wb_q);
      fwd_rs2_sel = fwd_sel(ex_q.use_rs2, ex_q.rs2, mem_q, wb_q);
    end
  end

  always_comb begin
    id_entry.valid   = id_valid && !bubble_ex;
    id_entry.rd      = id_rd_addr;
    id_entry.wb_en   = id_writeback_en;
    id_entry.is_load = id_is_load;
    id_entry.rs1     = id_rs1_addr;
    id_entry.rs2     = id_rs2_addr;
    id_entry.use_rs1 = id_use_rs1;
    id_entry.use_rs2 = id_use_rs2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q         <= '0;
      mem_q        <= '0;
      wb_q         <= '0;
      stall_cycles <= '0;
    end else begin
      if (stall_id && (stall_cycles != {CNT_W{1'b1}}))
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (!mem_stall) begin
        wb_q  <= mem_q;
        mem_q <= ex_q;
        ex_q  <= id_entry;
      end
    end
  end

endmodule

`default_nettype wire
